// File: rtl/fp_mul_pkg.sv
// Shared definitions for the sequential FP32 multiply wrapper.
//   state_t  : wrapper FSM states (IDLE -> EXEC -> WB -> IDLE)
//   FP_QNAN  : canonical quiet NaN produced by the multiplier core
//   OVF/ZERO/NEG : bit positions inside the core's mul_flags bus
//   is_nan() : true for any FP32 NaN encoding
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int OVF  = 3;
    localparam int ZERO = 2;
    localparam int NEG  = 0;

    function automatic logic is_nan(input logic [31:0] value);
        return (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_flag_map.sv
// Combinational mapping of a captured multiplier result/flags pair onto the
// architectural flag value and the exception events it raises.
//   res        in  32 : captured product
//   flags      in   4 : captured core flags ([3] ovf, [2] zero/NaN, [0] neg)
//   nzcv       out  4 : {N,Z,C,V} candidate value (C is always 0)
//   sticky_evt out  3 : {invalid, overflow, zero} events for this result
module fp_flag_map
    import fp_mul_pkg::*;
(
    input  logic [31:0] res,
    input  logic [3:0]  flags,
    output logic [3:0]  nzcv,
    output logic [2:0]  sticky_evt
);

    // flags[1] carries no meaning from the core; tie it off explicitly.
    logic flags_unused;
    assign flags_unused = flags[1];

    always_comb begin
        nzcv          = {flags[NEG], flags[ZERO], 1'b0, flags[OVF]};
        sticky_evt[2] = (res == FP_QNAN);
        sticky_evt[1] = flags[OVF];
        // The core reports NaN on the same flag as zero; only a real zero counts.
        sticky_evt[0] = flags[ZERO] && !is_nan(res);
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential wrapper around an external FP32 multiplier core.
// A request is accepted in IDLE, its operands are presented to the core for
// MUL_LAT cycles, the product is captured and offered on the writeback port
// until accepted; the handshake then updates NZCV (optionally) and the
// sticky exception bits.
//   clk, reset_n                 : clock, async active-low reset
//   req_valid/req_ready          : request handshake
//   req_a, req_b, req_rd, req_setflags : operands, destination, flag update
//   mul_a, mul_b / mul_res, mul_flags  : connection to the multiplier core
//   wb_valid/wb_ready, wb_data, wb_rd  : writeback handshake and payload
//   nzcv, sticky, sticky_clr     : architectural flags, sticky exceptions
//   busy                         : not IDLE
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_rd,
    input  logic        req_setflags,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_res,
    input  logic [3:0]  mul_flags,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic [3:0]  nzcv,
    output logic [2:0]  sticky,
    input  logic        sticky_clr,
    output logic        busy
);

    // Counter is loaded with MUL_LAT-1 so that EXEC lasts exactly MUL_LAT cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [31:0] mul_a_reg, mul_b_reg;
    logic [3:0]  rd_reg;
    logic        setflags_reg;
    logic [31:0] wb_data_reg;
    logic [3:0]  wb_rd_reg;
    logic [3:0]  flags_reg;
    logic [3:0]  nzcv_reg;
    logic [2:0]  sticky_reg, sticky_next;

    logic        accept;
    logic        exec_done;
    logic        wb_fire;
    logic [3:0]  map_nzcv;
    logic [2:0]  map_evt;
    logic [2:0]  set_evt;

    fp_flag_map u_flag_map (
        .res        (wb_data_reg),
        .flags      (flags_reg),
        .nzcv       (map_nzcv),
        .sticky_evt (map_evt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        busy       = 1'b1;
        wb_valid   = 1'b0;
        accept     = 1'b0;
        exec_done  = 1'b0;
        wb_fire    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                accept    = req_valid;
                if (req_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                exec_done = (cnt_reg == 4'd0);
                if (exec_done) begin
                    state_next = WB;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                wb_fire  = wb_ready;
                if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A clear and a set in the same cycle: the set bits survive, the rest clear.
    always_comb begin
        set_evt     = wb_fire ? map_evt : 3'b000;
        sticky_next = sticky_clr ? set_evt : (sticky_reg | set_evt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg      <= 4'd0;
            mul_a_reg    <= 32'd0;
            mul_b_reg    <= 32'd0;
            rd_reg       <= 4'd0;
            setflags_reg <= 1'b0;
            wb_data_reg  <= 32'd0;
            wb_rd_reg    <= 4'd0;
            flags_reg    <= 4'd0;
            nzcv_reg     <= 4'd0;
            sticky_reg   <= 3'd0;
        end else begin
            if (accept) begin
                mul_a_reg    <= req_a;
                mul_b_reg    <= req_b;
                rd_reg       <= req_rd;
                setflags_reg <= req_setflags;
                cnt_reg      <= LAT_LOAD;
            end else if (state_reg == EXEC && !exec_done) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            // Capture at the edge that ends the last EXEC cycle.
            if (exec_done) begin
                wb_data_reg <= mul_res;
                flags_reg   <= mul_flags;
                wb_rd_reg   <= rd_reg;
            end

            if (wb_fire && setflags_reg) begin
                nzcv_reg <= map_nzcv;
            end

            sticky_reg <= sticky_next;
        end
    end

    assign mul_a   = mul_a_reg;
    assign mul_b   = mul_b_reg;
    assign wb_data = wb_data_reg;
    assign wb_rd   = wb_rd_reg;
    assign nzcv    = nzcv_reg;
    assign sticky  = sticky_reg;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: a behavioural FP32 multiplier core is
// attached to a MUL_LAT=1 instance and a MUL_LAT=4 instance. Expected results
// are queued at request acceptance and checked at writeback.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FP32 multiplier core: truncating, denormals flushed.
    // Returns {flags[3:0], result[31:0]}.
    function automatic logic [35:0] fp_core(input logic [31:0] a, input logic [31:0] b);
        logic s, an, bn, ai, bi, az, bz;
        logic [47:0] p;
        logic [22:0] frac;
        int e;
        logic [31:0] r;
        logic [3:0] f;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        f  = 4'b0000;
        if (an || bn || (ai && bz) || (az && bi)) begin
            r = 32'h7FC00000;
            f[2] = 1'b1;
        end else if (ai || bi) begin
            r = {s, 8'hFF, 23'd0};
            f[0] = s;
        end else if (az || bz) begin
            r = {s, 31'd0};
            f[2] = 1'b1;
            f[0] = s;
        end else begin
            p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p[47]) begin
                frac = p[46:24];
                e = e + 1;
            end else begin
                frac = p[45:23];
            end
            f[0] = s;
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f[3] = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f[2] = 1'b1;
            end else begin
                r = {s, e[7:0], frac};
            end
        end
        return {f, r};
    endfunction

    // ---------------- MUL_LAT = 1 instance ----------------
    logic        req_valid = 1'b0, req_setflags = 1'b0, wb_ready = 1'b0, sticky_clr = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [3:0]  req_rd = '0;
    logic        req_ready, wb_valid, busy;
    logic [31:0] mul_a, mul_b, mul_res, wb_data;
    logic [3:0]  mul_flags, wb_rd, nzcv;
    logic [2:0]  sticky;

    assign {mul_flags, mul_res} = fp_core(mul_a, mul_b);

    fp_mul_seq #(.MUL_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_setflags(req_setflags),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .mul_flags(mul_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .nzcv(nzcv), .sticky(sticky), .sticky_clr(sticky_clr), .busy(busy)
    );

    // ---------------- MUL_LAT = 4 instance ----------------
    logic        req_valid_4 = 1'b0, req_setflags_4 = 1'b0, wb_ready_4 = 1'b0, sticky_clr_4 = 1'b0;
    logic [31:0] req_a_4 = '0, req_b_4 = '0;
    logic [3:0]  req_rd_4 = '0;
    logic        req_ready_4, wb_valid_4, busy_4;
    logic [31:0] mul_a_4, mul_b_4, mul_res_4, wb_data_4;
    logic [3:0]  mul_flags_4, wb_rd_4, nzcv_4;
    logic [2:0]  sticky_4;

    assign {mul_flags_4, mul_res_4} = fp_core(mul_a_4, mul_b_4);

    fp_mul_seq #(.MUL_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_a(req_a_4), .req_b(req_b_4), .req_rd(req_rd_4), .req_setflags(req_setflags_4),
        .mul_a(mul_a_4), .mul_b(mul_b_4), .mul_res(mul_res_4), .mul_flags(mul_flags_4),
        .wb_valid(wb_valid_4), .wb_ready(wb_ready_4), .wb_data(wb_data_4), .wb_rd(wb_rd_4),
        .nzcv(nzcv_4), .sticky(sticky_4), .sticky_clr(sticky_clr_4), .busy(busy_4)
    );

    // One full operation on the MUL_LAT=1 instance with wb_ready high.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic sf, input logic [31:0] exp_data,
                         input logic [3:0] exp_nzcv, input logic [2:0] exp_sticky,
                         input logic clr_at_wb);
        int n;
        int t_acc;
        exp_t e;
        @(negedge clk);
        req_a = a; req_b = b; req_rd = rd; req_setflags = sf; req_valid = 1'b1; wb_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_accept: req_ready=%b required 1", name, req_ready);
        end
        t_acc = cyc;
        sb_q.push_back('{data: exp_data, rd: rd});
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (wb_valid !== 1'b1 || (cyc - t_acc) != 2) begin
            n_fail++; $display("FAIL %s_latency: wb_valid=%b after %0d cycles, required 1 after 2", name, wb_valid, cyc - t_acc);
        end
        e = sb_q.pop_front();
        $display("txn %s: rd=%0d data=%h (expected rd=%0d data=%h)", name, wb_rd, wb_data, e.rd, e.data);
        n_checks++;
        if (wb_data !== e.data || wb_rd !== e.rd) begin
            n_fail++; $display("FAIL %s_data: wb_data=%h wb_rd=%0d required %h / %0d", name, wb_data, wb_rd, e.data, e.rd);
        end
        sticky_clr = clr_at_wb;
        @(negedge clk);
        sticky_clr = 1'b0;
        n_checks++;
        if (wb_valid !== 1'b0 || nzcv !== exp_nzcv || sticky !== exp_sticky) begin
            n_fail++; $display("FAIL %s_flags: wb_valid=%b nzcv=%b sticky=%b required 0 / %b / %b", name, wb_valid, nzcv, sticky, exp_nzcv, exp_sticky);
        end
        n_checks++;
        if (wb_data !== exp_data) begin
            n_fail++; $display("FAIL %s_hold: wb_data=%h required %h after handshake", name, wb_data, exp_data);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            n_fail++; $display("FAIL reset_hold: busy=%b wb_valid=%b mul_a=%h mul_b=%h required 0/0/0/0", busy, wb_valid, mul_a, mul_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: req_ready=%b busy=%b required 1/0", req_ready, busy);
        end
        n_checks++;
        if (wb_data !== 32'd0 || wb_rd !== 4'd0 || nzcv !== 4'd0 || sticky !== 3'd0) begin
            n_fail++; $display("FAIL reset_regs: wb_data=%h wb_rd=%h nzcv=%b sticky=%b required all 0", wb_data, wb_rd, nzcv, sticky);
        end
    endtask

    task automatic test_basic();
        do_op("basic", 32'h40000000, 32'h40400000, 4'd5, 1'b1, 32'h40C00000, 4'b0000, 3'b000, 1'b0);
    endtask

    task automatic test_negative();
        do_op("neg", 32'hC0000000, 32'h40400000, 4'd2, 1'b1, 32'hC0C00000, 4'b1000, 3'b000, 1'b0);
    endtask

    task automatic test_ovf_nan();
        do_op("ovf", 32'h7F000000, 32'h7F000000, 4'd3, 1'b1, 32'h7F800000, 4'b0001, 3'b010, 1'b0);
        do_op("nan", 32'h7FC00000, 32'h3F800000, 4'd4, 1'b1, 32'h7FC00000, 4'b0100, 3'b110, 1'b0);
    endtask

    task automatic test_nzcv_hold();
        do_op("ovf2", 32'h7F000000, 32'h7F000000, 4'd6, 1'b1, 32'h7F800000, 4'b0001, 3'b110, 1'b0);
        do_op("noflags", 32'hC0000000, 32'h40400000, 4'd8, 1'b0, 32'hC0C00000, 4'b0001, 3'b110, 1'b0);
    endtask

    task automatic test_sticky_clr();
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        n_checks++;
        if (sticky !== 3'b000 || nzcv !== 4'b0001) begin
            n_fail++; $display("FAIL sticky_clr: sticky=%b nzcv=%b required 000 / 0001", sticky, nzcv);
        end
        // NaN with setflags=0 sets only invalid; then a clear coinciding with overflow keeps overflow.
        do_op("nan_nf", 32'h7FC00000, 32'h40000000, 4'd9, 1'b0, 32'h7FC00000, 4'b0001, 3'b100, 1'b0);
        do_op("clr_set", 32'h7F000000, 32'h7F000000, 4'd10, 1'b1, 32'h7F800000, 4'b0001, 3'b010, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n;
        int t_acc;
        int t_hs;
        exp_t e;
        @(negedge clk);
        req_a = 32'h40000000; req_b = 32'h40400000; req_rd = 4'd1; req_setflags = 1'b0;
        req_valid = 1'b1; wb_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept1: req_ready=%b required 1", req_ready);
        end
        t_acc = cyc;
        sb_q.push_back('{data: 32'h40C00000, rd: 4'd1});
        @(negedge clk);
        req_a = 32'hC0000000; req_b = 32'h40400000; req_rd = 4'd7;
        n = 0;
        while (!wb_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (wb_valid !== 1'b1 || (cyc - t_acc) != 2) begin
            n_fail++; $display("FAIL b2b_latency1: wb_valid=%b after %0d cycles, required 1 after 2", wb_valid, cyc - t_acc);
        end
        e = sb_q.pop_front();
        $display("txn b2b_first: rd=%0d data=%h (expected rd=%0d data=%h)", wb_rd, wb_data, e.rd, e.data);
        n_checks++;
        if (wb_data !== e.data || wb_rd !== e.rd) begin
            n_fail++; $display("FAIL b2b_data1: wb_data=%h wb_rd=%0d required %h / %0d", wb_data, wb_rd, e.data, e.rd);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (wb_valid !== 1'b1 || wb_data !== 32'h40C00000 || wb_rd !== 4'd1 || req_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL b2b_stall%0d: wb_valid=%b wb_data=%h wb_rd=%0d req_ready=%b busy=%b required 1/40c00000/1/0/1",
                                   i, wb_valid, wb_data, wb_rd, req_ready, busy);
            end
        end
        wb_ready = 1'b1;
        t_hs = cyc;
        @(negedge clk);
        // Handshake happened; the held request is accepted on the next edge only.
        n_checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1 || mul_a !== 32'h40000000) begin
            n_fail++; $display("FAIL b2b_after_hs: wb_valid=%b req_ready=%b mul_a=%h required 0/1/40000000", wb_valid, req_ready, mul_a);
        end
        t_acc = cyc;
        n_checks++;
        if (t_acc != t_hs + 1) begin
            n_fail++; $display("FAIL b2b_accept2_cycle: accepted at %0d required %0d", t_acc, t_hs + 1);
        end
        sb_q.push_back('{data: 32'hC0C00000, rd: 4'd7});
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (wb_data !== 32'h40C00000 || mul_a !== 32'hC0000000) begin
            n_fail++; $display("FAIL b2b_hold: wb_data=%h mul_a=%h required 40c00000 / c0000000", wb_data, mul_a);
        end
        n = 0;
        while (!wb_valid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (wb_valid !== 1'b1 || (cyc - t_acc) != 2) begin
            n_fail++; $display("FAIL b2b_latency2: wb_valid=%b after %0d cycles, required 1 after 2", wb_valid, cyc - t_acc);
        end
        e = sb_q.pop_front();
        $display("txn b2b_second: rd=%0d data=%h (expected rd=%0d data=%h)", wb_rd, wb_data, e.rd, e.data);
        n_checks++;
        if (wb_data !== e.data || wb_rd !== e.rd) begin
            n_fail++; $display("FAIL b2b_data2: wb_data=%h wb_rd=%0d required %h / %0d", wb_data, wb_rd, e.data, e.rd);
        end
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done: wb_valid=%b required 0", wb_valid);
        end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        req_a = 32'h7F000000; req_b = 32'h7F000000; req_rd = 4'd11; req_setflags = 1'b1;
        req_valid = 1'b1; wb_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_exec_pre: busy=%b wb_valid=%b required 1/0", busy, wb_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || nzcv !== 4'd0 || sticky !== 3'd0) begin
            n_fail++; $display("FAIL rst_exec_async: busy=%b req_ready=%b nzcv=%b sticky=%b required 0/1/0000/000", busy, req_ready, nzcv, sticky);
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (wb_valid !== 1'b0 || nzcv !== 4'd0 || sticky !== 3'd0 || req_ready !== 1'b1) begin
                n_fail++; $display("FAIL rst_exec_after%0d: wb_valid=%b nzcv=%b sticky=%b req_ready=%b required 0/0000/000/1",
                                   i, wb_valid, nzcv, sticky, req_ready);
            end
        end
    endtask

    task automatic test_lat4();
        logic [31:0] va [2];
        logic [31:0] vd [2];
        logic [3:0]  vn [2];
        int n;
        int t_acc;
        exp_t e;
        va[0] = 32'h40000000; vd[0] = 32'h40C00000; vn[0] = 4'b0000;
        va[1] = 32'hC0000000; vd[1] = 32'hC0C00000; vn[1] = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_a_4 = va[k]; req_b_4 = 32'h40400000; req_rd_4 = 4'd5; req_setflags_4 = 1'b1;
            req_valid_4 = 1'b1; wb_ready_4 = 1'b1;
            n_checks++;
            if (req_ready_4 !== 1'b1) begin
                n_fail++; $display("FAIL lat4_accept%0d: req_ready=%b required 1", k, req_ready_4);
            end
            t_acc = cyc;
            sb_q.push_back('{data: vd[k], rd: 4'd5});
            @(negedge clk);
            req_valid_4 = 1'b0;
            n = 0;
            while (!wb_valid_4 && n < 50) begin
                n_checks++;
                if (mul_a_4 !== va[k] || mul_b_4 !== 32'h40400000) begin
                    n_fail++; $display("FAIL lat4_operands%0d: mul_a=%h mul_b=%h required %h / 40400000", k, mul_a_4, mul_b_4, va[k]);
                end
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (wb_valid_4 !== 1'b1 || (cyc - t_acc) != 5) begin
                n_fail++; $display("FAIL lat4_latency%0d: wb_valid=%b after %0d cycles, required 1 after 5", k, wb_valid_4, cyc - t_acc);
            end
            e = sb_q.pop_front();
            $display("txn lat4_%0d: rd=%0d data=%h (expected rd=%0d data=%h)", k, wb_rd_4, wb_data_4, e.rd, e.data);
            n_checks++;
            if (wb_data_4 !== e.data || wb_rd_4 !== e.rd) begin
                n_fail++; $display("FAIL lat4_data%0d: wb_data=%h wb_rd=%0d required %h / %0d", k, wb_data_4, wb_rd_4, e.data, e.rd);
            end
            @(negedge clk);
            n_checks++;
            if (wb_valid_4 !== 1'b0 || nzcv_4 !== vn[k] || sticky_4 !== 3'b000) begin
                n_fail++; $display("FAIL lat4_flags%0d: wb_valid=%b nzcv=%b sticky=%b required 0 / %b / 000", k, wb_valid_4, nzcv_4, sticky_4, vn[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ovf_nan();
        test_nzcv_hold();
        test_sticky_clr();
        test_back_to_back();
        test_reset_exec();
        test_lat4();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
